tpu_host_seq: RTL
=================

Name: tpu_host_seq

Overview:
- Host-side initiator that drives the TPU's memory-mapped slave bus (r_w / addr / dataIn / dataOut) through one complete matmul job.
- Accepts A and B operand rows on a valid/ready input stream.
- Optionally clears C, writes A rows and B rows, issues the matmul start command, then waits for the array to finish.
- Reads back C and returns it on a valid/ready output stream.

Parameters:
- DIM, 8, array dimension; rows of A, B, C.
- BITS_AB, 8, A/B element width.
- BITS_C, 16, C element width.
- ADDRW, 16, bus address width.
- DATAW, 64, bus data width; equals DIM*BITS_AB and (DIM/2)*BITS_C.
- MATMUL_CYCLES, 32, idle cycles after the start command before C is read; must be at least the TPU's internal matmul count length.
- CLEAR_C, 1, if 1 then write zero to all C halves before loading A.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle job request
- busy  out  1  job in progress
- done  out  1  one-cycle pulse after last C word accepted
- in_valid  in  1  operand word valid
- in_ready  out  1  operand word accepted when in_valid & in_ready
- in_data  in  DATAW  operand word: DIM A rows (row 0 first), then DIM B words
- out_valid  out  1  C word valid
- out_ready  in  1  consumer accepts C word
- out_data  out  DATAW  C half-row; low half (elements 0..DIM/2-1) first
- tpu_r_w  out  1  bus direction, 0=read, 1=write
- tpu_addr  out  ADDRW  bus address
- tpu_wdata  out  DATAW  to TPU dataIn
- tpu_rdata  in  DATAW  from TPU dataOut; combinational function of tpu_addr

Behaviour:
- Bus outputs are registered.
- Idle bus value is tpu_r_w=0, tpu_addr=0, tpu_wdata=0; function nibble 0 is a no-op.
- Every write is exactly one cycle; the bus returns to idle the next cycle unless another write follows.
- Address map (addr[11:8] = function):
  - 0x1 = A write, row in addr[5:3].
  - 0x2 = B write; successive writes shift in, low bits written as k<<3.
  - 0x3 = C access, row in addr[6:4], half in addr[3].
  - 0x4 = matmul start.
- Reset (async): state IDLE, busy=0, done=0, in_ready=0, out_valid=0, out_data=0, bus idle, all counters 0. Reset mid-job abandons the job with no further bus activity.
- States:
  - IDLE: busy=0. start -> CLR_C if CLEAR_C, else LOAD_A. start while busy is ignored.
  - CLR_C: one write per cycle, r_w=1, wdata=0, addr=0x300|(r<<4)|(h<<3), for r=0..DIM-1 and h=0..1 (2*DIM cycles), then LOAD_A.
  - LOAD_A: in_ready=1. Each accepted word k produces one write next cycle: addr=0x100|(k<<3), wdata=in_data. After DIM accepts -> LOAD_B. Gaps in in_valid stall the sequence; the bus is idle during gaps.
  - LOAD_B: same as LOAD_A with addr=0x200|(k<<3). After DIM accepts -> START. in_ready drops in the cycle following the DIM-th accept.
  - START: one write with addr=0x400, wdata=0, then WAIT.
  - WAIT: bus idle for exactly MATMUL_CYCLES cycles (down-counter), then READ.
  - READ, word index j=0..2*DIM-1, row=j>>1, half=j&1:
    - Present r_w=0, addr=0x300|(row<<4)|(half<<3).
    - On the next edge, capture tpu_rdata into out_data and set out_valid.
    - Hold addr and out_data stable while out_valid & !out_ready.
    - On accept, clear out_valid, increment j, and update addr in the same edge.
    - Throughput is 1 word per 2 cycles with out_ready held high.
    - After the last accept -> DONE.
  - DONE: done=1 for one cycle, bus idle, -> IDLE.
- busy=1 in every state except IDLE.
- in_ready=0 outside LOAD_A/LOAD_B.
- Bus writes never occur in READ or WAIT.
- in_valid outside the load states is ignored; no data is consumed.

Test Plan:
1. Reset mid-LOAD_A (after 3 accepts), with rst_n low asynchronously between edges -> bus idle, busy=0, in_ready=0 immediately; a new start runs a full job from A row 0.
2. CLEAR_C=1, start, with in_valid held high and 16 distinct words -> bus write sequence:
   - 16 zero writes 0x300,0x308,0x310..0x378;
   - then 0x100..0x138;
   - then 0x200..0x238;
   - then one 0x400;
   - then exactly 32 idle cycles;
   - then first read addr 0x300.
3. in_valid toggling every other cycle during the load states -> one write per accepted word, idle bus in gaps, no dropped or duplicated rows.
4. out_ready low for 5 cycles on word j=3 -> addr stays 0x318 and out_data stays stable; the word is accepted once, then addr advances to 0x320.
5. End-to-end against a real TPU instance with A=identity and B rows filled with distinct values -> the 16 C words returned match the golden A×B result.
6. start pulsed during WAIT -> ignored; exactly one done pulse per job.

Source files
------------

// File: rtl/tpu_host_seq_if.sv
// Host-side bundle for tpu_host_seq: job control, operand input stream,
// C result output stream and the TPU memory-mapped slave bus.
interface tpu_host_seq_if #(
  parameter int ADDRW = 16,
  parameter int DATAW = 64
);
  // Streams: a word moves on a rising edge where valid & ready are both high.
  // The producer holds valid and data steady until that happens, and valid
  // never waits on ready.
  logic             start;
  logic             busy;
  logic             done;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [DATAW-1:0] out_data;
  logic             tpu_r_w;
  logic [ADDRW-1:0] tpu_addr;
  logic [DATAW-1:0] tpu_wdata;
  logic [DATAW-1:0] tpu_rdata;

  modport master (
    input  start, in_valid, in_data, out_ready, tpu_rdata,
    output busy, done, in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
  );

  modport slave (
    output start, in_valid, in_data, out_ready, tpu_rdata,
    input  busy, done, in_ready, out_valid, out_data, tpu_r_w, tpu_addr, tpu_wdata
  );
endinterface

// File: rtl/tpu_host_seq.sv
// Sequences one TPU matmul job over the slave bus: optional C clear, A/B load,
// start, fixed wait, then C read-back onto a valid/ready output stream.
module tpu_host_seq #(
  parameter int DIM           = 8,
  parameter int BITS_AB       = 8,
  parameter int BITS_C        = 16,
  parameter int ADDRW         = 16,
  parameter int DATAW         = 64,
  parameter int MATMUL_CYCLES = 32,
  parameter int CLEAR_C       = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  tpu_host_seq_if.master   io,
  output logic [2:0]       dbg_state
);
  // C rows span several bus words; the array is square, so one bus word of
  // A/B elements is one row and there are as many rows as elements per word.
  localparam int N_C    = DIM * ((DIM * BITS_C) / DATAW);
  localparam int LOAD_N = DATAW / BITS_AB;
  localparam int CW     = $clog2(N_C) + 1;
  localparam int WW     = $clog2(MATMUL_CYCLES + 1);

  localparam logic [CW-1:0] LAST_C    = CW'(N_C - 1);
  localparam logic [CW-1:0] LAST_LOAD = CW'(LOAD_N - 1);

  localparam logic [ADDRW-1:0] FN_A     = ADDRW'('h100);
  localparam logic [ADDRW-1:0] FN_B     = ADDRW'('h200);
  localparam logic [ADDRW-1:0] FN_C     = ADDRW'('h300);
  localparam logic [ADDRW-1:0] FN_START = ADDRW'('h400);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR_C  = 3'd1;
  localparam logic [2:0] S_LOAD_A = 3'd2;
  localparam logic [2:0] S_LOAD_B = 3'd3;
  localparam logic [2:0] S_START  = 3'd4;
  localparam logic [2:0] S_WAIT   = 3'd5;
  localparam logic [2:0] S_READ   = 3'd6;
  localparam logic [2:0] S_DONE   = 3'd7;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [WW-1:0] wait_cnt;
  logic          in_fire;

  // Row/half slots are 8-byte strides, so (row<<4)|(half<<3) is just idx<<3.
  function automatic logic [ADDRW-1:0] slot(input logic [ADDRW-1:0] base,
                                            input logic [CW-1:0]    idx);
    return base | (ADDRW'(idx) << 3);
  endfunction

  assign io.busy     = (state != S_IDLE);
  assign io.done     = (state == S_DONE);
  assign io.in_ready = (state == S_LOAD_A) || (state == S_LOAD_B);
  assign in_fire     = io.in_valid & io.in_ready;
  assign dbg_state   = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      wait_cnt     <= '0;
      io.out_valid <= 1'b0;
      io.out_data  <= '0;
      io.tpu_r_w   <= 1'b0;
      io.tpu_addr  <= '0;
      io.tpu_wdata <= '0;
    end else begin
      // Bus falls back to idle unless the current state drives it this cycle.
      io.tpu_r_w   <= 1'b0;
      io.tpu_addr  <= '0;
      io.tpu_wdata <= '0;
      case (state)
        S_IDLE: begin
          if (io.start) begin
            cnt   <= '0;
            state <= (CLEAR_C != 0) ? S_CLR_C : S_LOAD_A;
          end
        end
        S_CLR_C: begin
          io.tpu_r_w  <= 1'b1;
          io.tpu_addr <= slot(FN_C, cnt);
          if (cnt == LAST_C) begin
            cnt   <= '0;
            state <= S_LOAD_A;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_LOAD_A, S_LOAD_B: begin
          if (in_fire) begin
            io.tpu_r_w   <= 1'b1;
            io.tpu_addr  <= slot((state == S_LOAD_A) ? FN_A : FN_B, cnt);
            io.tpu_wdata <= io.in_data;
            if (cnt == LAST_LOAD) begin
              cnt   <= '0;
              state <= (state == S_LOAD_A) ? S_LOAD_B : S_START;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
        end
        S_START: begin
          io.tpu_r_w  <= 1'b1;
          io.tpu_addr <= FN_START;
          wait_cnt    <= WW'(MATMUL_CYCLES);
          state       <= S_WAIT;
        end
        S_WAIT: begin
          // Counter is loaded with the full length, so the read address lands
          // after exactly MATMUL_CYCLES idle bus cycles.
          if (wait_cnt == '0) begin
            io.tpu_addr <= slot(FN_C, '0);
            state       <= S_READ;
          end else begin
            wait_cnt <= wait_cnt - WW'(1);
          end
        end
        S_READ: begin
          io.tpu_addr <= slot(FN_C, cnt);
          if (!io.out_valid) begin
            io.out_data  <= io.tpu_rdata;
            io.out_valid <= 1'b1;
          end else if (io.out_ready) begin
            io.out_valid <= 1'b0;
            if (cnt == LAST_C) begin
              cnt         <= '0;
              io.tpu_addr <= '0;
              state       <= S_DONE;
            end else begin
              cnt         <= cnt + CW'(1);
              io.tpu_addr <= slot(FN_C, cnt + CW'(1));
            end
          end
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
